// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU arbiter slice.
// FSM state encoding, FPU command codes, default operand width.
package fpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } fpu_arb_state_e;

    localparam logic [3:0] FPU_CMD_ADD   = 4'd0;
    localparam int         FPU_BUS_WIDTH = 32;

endpackage

// File: rtl/fpu_rr_arbiter2.sv
// Combinational 2-way round-robin grant.
// Ports: i_last (last granted id), i_valid[1:0] -> o_grant[1:0] one-hot.
module fpu_rr_arbiter2 (
    input  logic       i_last,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = i_valid;
        // On a tie the requester not served last time wins.
        if (&i_valid) begin
            o_grant = i_last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one combinational FPU between two valid/ready requesters.
// Ports: clk, rst (sync, active-high); req0/1 valid/ready/a/b/cmd;
//   rsp0/1 valid/ready/result; fpu_ain/bin/cmd out, fpu_result in;
//   busy. Macro FPU_ARB_PERF_EN adds grant_cnt0/1 and stall_cnt.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int BUS_WIDTH = FPU_BUS_WIDTH,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [BUS_WIDTH-1:0] req0_a,
    input  logic [BUS_WIDTH-1:0] req0_b,
    input  logic [3:0]           req0_cmd,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [BUS_WIDTH-1:0] req1_a,
    input  logic [BUS_WIDTH-1:0] req1_b,
    input  logic [3:0]           req1_cmd,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [BUS_WIDTH-1:0] rsp0_result,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [BUS_WIDTH-1:0] rsp1_result,
    output logic [BUS_WIDTH-1:0] fpu_ain,
    output logic [BUS_WIDTH-1:0] fpu_bin,
    output logic [3:0]           fpu_cmd,
    input  logic [BUS_WIDTH-1:0] fpu_result,
`ifdef FPU_ARB_PERF_EN
    output logic [15:0]          grant_cnt0,
    output logic [15:0]          grant_cnt1,
    output logic [15:0]          stall_cnt,
`endif
    output logic                 busy
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    fpu_arb_state_e       r_state;
    fpu_arb_state_e       w_state_nxt;
    logic                 r_last;
    logic                 r_owner;
    logic [3:0]           r_cnt;
    logic [BUS_WIDTH-1:0] r_ain;
    logic [BUS_WIDTH-1:0] r_bin;
    logic [3:0]           r_cmd;
    logic [1:0]           r_rsp_valid;
    logic [BUS_WIDTH-1:0] r_res0;
    logic [BUS_WIDTH-1:0] r_res1;

    logic [1:0]           w_grant;
    logic [1:0]           w_ready;
    logic                 w_hs;
    logic                 w_win;
    logic                 w_rsp_take;

    fpu_rr_arbiter2 u_rr (
        .i_last  (r_last),
        .i_valid ({req1_valid, req0_valid}),
        .o_grant (w_grant)
    );

    // Grant only matters while idle; a grant implies its valid.
    assign w_ready    = (r_state == IDLE) ? w_grant : 2'b00;
    assign w_hs       = |w_ready;
    assign w_win      = w_ready[1];
    assign w_rsp_take = (r_state == RESP) &&
                        (r_owner ? rsp1_ready : rsp0_ready);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_hs) w_state_nxt = EXEC;
            EXEC: if (r_cnt == 4'd0) w_state_nxt = RESP;
            RESP: if (w_rsp_take) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_cnt       <= 4'd0;
            r_ain       <= '0;
            r_bin       <= '0;
            r_cmd       <= FPU_CMD_ADD;
            r_rsp_valid <= 2'b00;
            r_res0      <= '0;
            r_res1      <= '0;
        end else begin
            if (w_hs) begin
                r_ain   <= w_win ? req1_a : req0_a;
                r_bin   <= w_win ? req1_b : req0_b;
                r_cmd   <= w_win ? req1_cmd : req0_cmd;
                r_owner <= w_win;
                r_last  <= w_win;
                r_cnt   <= LAT_M1;
            end
            if (r_state == EXEC) begin
                if (r_cnt == 4'd0) begin
                    if (r_owner) begin
                        r_res1         <= fpu_result;
                        r_rsp_valid[1] <= 1'b1;
                    end else begin
                        r_res0         <= fpu_result;
                        r_rsp_valid[0] <= 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
            if (w_rsp_take) begin
                r_rsp_valid <= 2'b00;
            end
        end
    end

    assign req0_ready  = w_ready[0];
    assign req1_ready  = w_ready[1];
    assign rsp0_valid  = r_rsp_valid[0];
    assign rsp1_valid  = r_rsp_valid[1];
    assign rsp0_result = r_res0;
    assign rsp1_result = r_res1;
    assign fpu_ain     = r_ain;
    assign fpu_bin     = r_bin;
    assign fpu_cmd     = r_cmd;
    assign busy        = (r_state != IDLE);

`ifdef FPU_ARB_PERF_EN
    logic [15:0] r_gcnt0;
    logic [15:0] r_gcnt1;
    logic [15:0] r_stall;
    logic        w_stall;

    assign w_stall = (req0_valid && !w_ready[0]) ||
                     (req1_valid && !w_ready[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gcnt0 <= 16'd0;
            r_gcnt1 <= 16'd0;
            r_stall <= 16'd0;
        end else begin
            if (w_ready[0] && r_gcnt0 != 16'hFFFF) r_gcnt0 <= r_gcnt0 + 16'd1;
            if (w_ready[1] && r_gcnt1 != 16'hFFFF) r_gcnt1 <= r_gcnt1 + 16'd1;
            if (w_stall && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
        end
    end

    assign grant_cnt0 = r_gcnt0;
    assign grant_cnt1 = r_gcnt1;
    assign stall_cnt  = r_stall;
`endif

endmodule
